// File: rtl/spec_fifo_pkg.sv
// Shared sizing helpers and control-priority encoding for the speculative
// checkpoint FIFO.
package spec_fifo_pkg;

  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int calc_pw(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int calc_cw(input int num_ckpt);
    return (num_ckpt <= 1) ? 1 : $clog2(num_ckpt);
  endfunction

  localparam int DEF_DEPTH    = 16;
  localparam int DEF_NUM_CKPT = 4;
  localparam int DEF_PW       = calc_pw(DEF_DEPTH);

  typedef logic [DEF_PW-1:0] ptr_t;

  // Highest-priority request wins each cycle; lower ones are ignored.
  typedef enum logic [2:0] {
    CTL_NONE,
    CTL_MARK,
    CTL_ROLLBACK,
    CTL_REVERT,
    CTL_COMMIT
  } ctl_e;

endpackage

// File: rtl/spec_fifo_ckpt_if.sv
// Producer/consumer bundle of the speculative FIFO; master drives requests,
// slave is the FIFO itself.
interface spec_fifo_ckpt_if
  import spec_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int NUM_CKPT = 4
);
  localparam int PW = calc_pw(DEPTH);
  localparam int CW = calc_cw(NUM_CKPT);

  logic             ready_in;
  logic             valid_in;
  logic [WIDTH-1:0] data_in;
  logic             mark;
  logic             mark_ready;
  logic [CW-1:0]    mark_id;
  logic             rollback;
  logic [CW-1:0]    rollback_id;
  logic             revert;
  logic             commit;
  logic             ready_out;
  logic             valid_out;
  logic [WIDTH-1:0] data_out;
  logic [PW-1:0]    commit_count;
  logic [PW-1:0]    spec_count;
  logic [CW:0]      ckpt_count;

  modport master (
    input  ready_in, mark_ready, mark_id, valid_out, data_out,
           commit_count, spec_count, ckpt_count,
    output valid_in, data_in, mark, rollback, rollback_id, revert, commit,
           ready_out
  );

  modport slave (
    output ready_in, mark_ready, mark_id, valid_out, data_out,
           commit_count, spec_count, ckpt_count,
    input  valid_in, data_in, mark, rollback, rollback_id, revert, commit,
           ready_out
  );

endinterface

// File: rtl/spec_fifo_ckpt_ckpt_stack.sv
// LIFO of saved speculative write pointers with push, truncate-to-id and
// clear; any entry can be read by id for rollback.
module ckpt_stack #(
  parameter int NUM_CKPT = 4,
  parameter int PW       = 5,
  parameter int CW       = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [PW-1:0] push_ptr,
  input  logic          truncate,
  input  logic [CW-1:0] trunc_id,
  input  logic          clear,
  input  logic [CW-1:0] rd_id,
  output logic [PW-1:0] sel_ptr,
  output logic [CW:0]   count,
  output logic          full
);
  localparam logic [CW:0] MAX_CNT = (CW+1)'(NUM_CKPT);

  logic [PW-1:0] stack [NUM_CKPT];
  logic [CW:0]   cnt;
  logic          trunc_ok;

  assign count    = cnt;
  assign full     = (cnt == MAX_CNT);
  assign sel_ptr  = stack[rd_id];
  assign trunc_ok = ({1'b0, trunc_id} < cnt);

  always_ff @(posedge clk) begin
    if (push && !full)
      stack[cnt[CW-1:0]] <= push_ptr;
  end

  // Operations are mutually exclusive from the caller; clear dominates anyway.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (truncate && trunc_ok)
      cnt <= {1'b0, trunc_id};
    else if (push && !full)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/spec_fifo_ckpt.sv
// Speculative FIFO: producer writes ahead of a commit point with nested
// checkpoints; the consumer only ever sees committed entries.
module spec_fifo_ckpt
  import spec_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int NUM_CKPT = 4
) (
  input logic             clk,
  input logic             reset,
  spec_fifo_ckpt_if.slave bus
);
  localparam int AW = calc_aw(DEPTH);
  localparam int PW = calc_pw(DEPTH);
  localparam int CW = calc_cw(NUM_CKPT);
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    spec_wr_ptr;
  logic [PW-1:0]    spec_cnt;
  logic [PW-1:0]    commit_cnt;
  logic [PW-1:0]    ckpt_ptr;
  logic [PW-1:0]    spec_next;
  logic [CW:0]      ckpt_cnt;
  logic             ckpt_full;
  logic             write;
  logic             read;
  logic             rb_legal;
  ctl_e             ctl;

  assign spec_cnt   = spec_wr_ptr - rd_ptr;
  assign commit_cnt = wr_ptr - rd_ptr;
  assign write      = bus.valid_in & bus.ready_in;
  assign read       = bus.ready_out & bus.valid_out;
  assign rb_legal   = ({1'b0, bus.rollback_id} < ckpt_cnt);
  assign spec_next  = spec_wr_ptr + {{(PW-1){1'b0}}, write};

  assign bus.ready_in     = (spec_cnt != FULL_LVL);
  assign bus.valid_out    = (commit_cnt != '0);
  assign bus.data_out     = mem[rd_ptr[AW-1:0]];
  assign bus.commit_count = commit_cnt;
  assign bus.spec_count   = spec_cnt;
  assign bus.ckpt_count   = ckpt_cnt;
  assign bus.mark_ready   = !ckpt_full;
  assign bus.mark_id      = ckpt_cnt[CW-1:0];

  always_comb begin
    ctl = CTL_NONE;
    if (bus.commit)
      ctl = CTL_COMMIT;
    else if (bus.revert)
      ctl = CTL_REVERT;
    else if (bus.rollback && rb_legal)
      ctl = CTL_ROLLBACK;
    else if (bus.mark && !ckpt_full)
      ctl = CTL_MARK;
  end

  ckpt_stack #(
    .NUM_CKPT (NUM_CKPT),
    .PW       (PW),
    .CW       (CW)
  ) u_ckpt_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (ctl == CTL_MARK),
    .push_ptr (spec_wr_ptr),
    .truncate (ctl == CTL_ROLLBACK),
    .trunc_id (bus.rollback_id),
    .clear    ((ctl == CTL_COMMIT) || (ctl == CTL_REVERT)),
    .rd_id    (bus.rollback_id),
    .sel_ptr  (ckpt_ptr),
    .count    (ckpt_cnt),
    .full     (ckpt_full)
  );

  // A discarded write may still land in memory: the slot is beyond every
  // committed entry, so nothing visible is disturbed.
  always_ff @(posedge clk) begin
    if (write)
      mem[spec_wr_ptr[AW-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      spec_wr_ptr <= '0;
    end else begin
      if (read)
        rd_ptr <= rd_ptr + 1'b1;
      case (ctl)
        CTL_COMMIT: begin
          wr_ptr      <= spec_next;
          spec_wr_ptr <= spec_next;
        end
        CTL_REVERT:   spec_wr_ptr <= wr_ptr;
        CTL_ROLLBACK: spec_wr_ptr <= ckpt_ptr;
        default:      spec_wr_ptr <= spec_next;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.rollback && !bus.commit && !bus.revert)
        assert (rb_legal)
          else $warning("rollback_id %0d ignored, only %0d checkpoints held",
                        bus.rollback_id, ckpt_cnt);
      if (bus.mark && !bus.commit && !bus.revert && !(bus.rollback && rb_legal))
        assert (!ckpt_full)
          else $warning("mark dropped, checkpoint stack full");
    end
  end

endmodule

// File: tb/tb_spec_fifo_ckpt.sv
// Directed bench for spec_fifo_ckpt with a queue-based reference model.
module tb_spec_fifo_ckpt;
  import spec_fifo_pkg::*;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 16;
  localparam int NUM_CKPT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spec_fifo_ckpt_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CKPT(NUM_CKPT)) bus ();

  spec_fifo_ckpt #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CKPT(NUM_CKPT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: committed entries, speculative entries, and per-checkpoint
  // length of the speculative queue at the time of the mark.
  logic [7:0] com_q[$];
  logic [7:0] spec_q[$];
  int         ck_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit wr;
    bit rd;
    int id;
    if (reset) begin
      com_q.delete();
      spec_q.delete();
      ck_q.delete();
    end else begin
      wr = bus.valid_in && ((com_q.size() + spec_q.size()) != DEPTH);
      rd = bus.ready_out && (com_q.size() != 0);
      if (rd) void'(com_q.pop_front());
      if (bus.commit) begin
        if (wr) spec_q.push_back(bus.data_in);
        foreach (spec_q[i]) com_q.push_back(spec_q[i]);
        spec_q.delete();
        ck_q.delete();
      end else if (bus.revert) begin
        spec_q.delete();
        ck_q.delete();
      end else if (bus.rollback && (int'(bus.rollback_id) < ck_q.size())) begin
        id = int'(bus.rollback_id);
        while (spec_q.size() > ck_q[id]) void'(spec_q.pop_back());
        while (ck_q.size() > id) void'(ck_q.pop_back());
      end else begin
        if (bus.mark && (ck_q.size() < NUM_CKPT)) ck_q.push_back(spec_q.size());
        if (wr) spec_q.push_back(bus.data_in);
      end
    end
  end

  always @(negedge clk) begin : compare
    int sc;
    sc = com_q.size() + spec_q.size();
    chk("m_ready_in",     int'(bus.ready_in),     int'(sc != DEPTH));
    chk("m_valid_out",    int'(bus.valid_out),    int'(com_q.size() != 0));
    chk("m_commit_count", int'(bus.commit_count), com_q.size());
    chk("m_spec_count",   int'(bus.spec_count),   sc);
    chk("m_ckpt_count",   int'(bus.ckpt_count),   ck_q.size());
    chk("m_mark_ready",   int'(bus.mark_ready),   int'(ck_q.size() != NUM_CKPT));
    if (ck_q.size() < NUM_CKPT)
      chk("m_mark_id", int'(bus.mark_id), ck_q.size());
    if (com_q.size() != 0)
      chk("m_data_out", int'(bus.data_out), int'(com_q[0]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.valid_in    = 1'b0;
    bus.mark        = 1'b0;
    bus.rollback    = 1'b0;
    bus.rollback_id = '0;
    bus.revert      = 1'b0;
    bus.commit      = 1'b0;
    bus.ready_out   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    tick();
  endtask

  task automatic rdx(input int exp, input string nm);
    chk({nm, "_valid"}, int'(bus.valid_out), 1);
    chk({nm, "_data"},  int'(bus.data_out),  exp);
    bus.ready_out = 1'b1;
    tick();
  endtask

  initial begin
    bus.valid_in    = 1'b0;
    bus.data_in     = '0;
    bus.mark        = 1'b0;
    bus.rollback    = 1'b0;
    bus.rollback_id = '0;
    bus.revert      = 1'b0;
    bus.commit      = 1'b0;
    bus.ready_out   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_ready_in",   int'(bus.ready_in),     1);
    chk("rst_valid_out",  int'(bus.valid_out),    0);
    chk("rst_mark_ready", int'(bus.mark_ready),   1);
    chk("rst_mark_id",    int'(bus.mark_id),      0);
    chk("rst_spec",       int'(bus.spec_count),   0);
    chk("rst_commit",     int'(bus.commit_count), 0);
    chk("rst_ckpt",       int'(bus.ckpt_count),   0);

    // basic commit
    for (int i = 0; i < 5; i++) wr(8'(16 + i));
    chk("basic_pre_valid", int'(bus.valid_out),  0);
    chk("basic_pre_spec",  int'(bus.spec_count), 5);
    bus.commit = 1'b1;
    tick();
    chk("basic_commit_count", int'(bus.commit_count), 5);
    for (int i = 0; i < 5; i++) rdx(16 + i, $sformatf("basic_rd%0d", i));
    chk("basic_empty", int'(bus.valid_out), 0);

    // full capacity, refused write, wrap of pointers
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_ready%0d", i), int'(bus.ready_in), 1);
      wr(8'(32 + i));
    end
    chk("full_ready_in", int'(bus.ready_in),   0);
    chk("full_spec",     int'(bus.spec_count), 16);
    bus.valid_in = 1'b1;
    bus.data_in  = 8'hEE;
    tick();
    chk("full_refused", int'(bus.spec_count), 16);
    bus.commit = 1'b1;
    tick();
    chk("full_commit", int'(bus.commit_count), 16);
    chk("fullrd_a_data", int'(bus.data_out), 8'h20);
    bus.valid_in  = 1'b1;
    bus.data_in   = 8'hEE;
    bus.ready_out = 1'b1;
    tick();
    chk("fullrd_a_spec",   int'(bus.spec_count),   15);
    chk("fullrd_a_commit", int'(bus.commit_count), 15);
    chk("fullrd_b_data", int'(bus.data_out), 8'h21);
    bus.valid_in  = 1'b1;
    bus.data_in   = 8'hEE;
    bus.ready_out = 1'b1;
    tick();
    chk("fullrd_b_spec",   int'(bus.spec_count),   15);
    chk("fullrd_b_commit", int'(bus.commit_count), 14);
    for (int i = 2; i < 16; i++) rdx(32 + i, $sformatf("full_rd%0d", i));
    chk("full_left_spec", int'(bus.spec_count), 1);
    bus.revert = 1'b1;
    tick();
    chk("full_revert_spec", int'(bus.spec_count), 0);

    // nested rollback
    wr(8'hA1);
    chk("nest_id0", int'(bus.mark_id), 0);
    bus.mark = 1'b1;
    tick();
    wr(8'hB2);
    chk("nest_id1", int'(bus.mark_id), 1);
    bus.mark = 1'b1;
    tick();
    wr(8'hC3);
    bus.rollback = 1'b1; bus.rollback_id = 2'd1;
    tick();
    chk("nest_rb1_spec", int'(bus.spec_count), 2);
    chk("nest_rb1_ckpt", int'(bus.ckpt_count), 1);
    bus.rollback = 1'b1; bus.rollback_id = 2'd0;
    tick();
    chk("nest_rb0_spec", int'(bus.spec_count), 1);
    chk("nest_rb0_ckpt", int'(bus.ckpt_count), 0);
    bus.commit = 1'b1;
    tick();
    rdx(8'hA1, "nest_rdA");
    chk("nest_only_a", int'(bus.valid_out), 0);

    // simultaneous events
    bus.valid_in = 1'b1; bus.data_in = 8'hD4; bus.commit = 1'b1;
    tick();
    chk("sim_commit_wr", int'(bus.commit_count), 1);
    rdx(8'hD4, "sim_rdD");
    wr(8'h31);
    bus.valid_in = 1'b1; bus.data_in = 8'hE5; bus.revert = 1'b1;
    tick();
    chk("sim_revert_spec",   int'(bus.spec_count),   0);
    chk("sim_revert_commit", int'(bus.commit_count), 0);
    wr(8'h32);
    bus.valid_in = 1'b1; bus.data_in = 8'h33; bus.commit = 1'b1; bus.revert = 1'b1;
    tick();
    chk("sim_commit_wins", int'(bus.commit_count), 2);
    rdx(8'h32, "sim_rd32");
    rdx(8'h33, "sim_rd33");
    bus.mark = 1'b1; bus.valid_in = 1'b1; bus.data_in = 8'hF6;
    tick();
    chk("sim_markwr_ckpt", int'(bus.ckpt_count), 1);
    chk("sim_markwr_spec", int'(bus.spec_count), 1);
    bus.rollback = 1'b1; bus.rollback_id = 2'd0;
    tick();
    chk("sim_rb_f_gone", int'(bus.spec_count), 0);

    // checkpoint overflow and illegal id
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_id%0d", i), int'(bus.mark_id), i);
      bus.mark = 1'b1; bus.valid_in = 1'b1; bus.data_in = 8'(64 + i);
      tick();
    end
    chk("ovf_mark_ready", int'(bus.mark_ready), 0);
    chk("ovf_ckpt4",      int'(bus.ckpt_count), 4);
    bus.mark = 1'b1;
    tick();
    chk("ovf_5th_ignored", int'(bus.ckpt_count), 4);
    bus.commit = 1'b1;
    tick();
    chk("ovf_commit_ckpt", int'(bus.ckpt_count), 0);
    bus.rollback = 1'b1; bus.rollback_id = 2'd2;
    tick();
    chk("ill_rb_spec",   int'(bus.spec_count),   4);
    chk("ill_rb_commit", int'(bus.commit_count), 4);
    chk("ill_rb_ckpt",   int'(bus.ckpt_count),   0);
    for (int i = 0; i < 4; i++) rdx(64 + i, $sformatf("ovf_rd%0d", i));

    // reset mid-operation
    wr(8'h50);
    bus.commit = 1'b1;
    tick();
    wr(8'h51);
    bus.mark = 1'b1;
    tick();
    wr(8'h52);
    bus.mark = 1'b1;
    tick();
    chk("mid_pre_ckpt", int'(bus.ckpt_count), 2);
    chk("mid_pre_spec", int'(bus.spec_count), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_spec",       int'(bus.spec_count),   0);
    chk("mid_commit",     int'(bus.commit_count), 0);
    chk("mid_ckpt",       int'(bus.ckpt_count),   0);
    chk("mid_valid_out",  int'(bus.valid_out),    0);
    chk("mid_ready_in",   int'(bus.ready_in),     1);
    chk("mid_mark_id",    int'(bus.mark_id),      0);
    wr(8'h60);
    bus.commit = 1'b1;
    tick();
    rdx(8'h60, "mid_rd60");
    chk("mid_final_empty", int'(bus.valid_out), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spec_fifo_ckpt.md
Name: spec_fifo_ckpt

Overview:
- Speculative FIFO with up to NUM_CKPT nested checkpoints inside the uncommitted region.
- The producer writes speculatively and can mark checkpoints. It can roll back to any checkpoint, revert everything uncommitted, or commit everything written so far.
- The consumer sees only committed entries.
- All DEPTH entries are usable: pointers carry one extra wrap bit.
- Sits between a speculative producer (decoder, packet parser) and a non-speculative consumer.

Parameters:
- WIDTH, 8, data bits per entry.
- DEPTH, 16, entry count; must be a power of 2, minimum 2.
- NUM_CKPT, 4, maximum outstanding checkpoints; minimum 1.
- Derived in the package: AW = $clog2(DEPTH), PW = AW+1 (pointer and count width), CW = $clog2(NUM_CKPT) with a minimum of 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- ready_in  out  1  FIFO can accept a write.
- valid_in  in  1  write request.
- data_in  in  WIDTH  write data.
- mark  in  1  push a checkpoint at the current speculative write pointer.
- mark_ready  out  1  checkpoint stack not full.
- mark_id  out  CW  id assigned to a mark accepted this cycle; equals the current checkpoint count.
- rollback  in  1  roll back to checkpoint rollback_id.
- rollback_id  in  CW  checkpoint to restore.
- revert  in  1  discard all uncommitted writes.
- commit  in  1  publish all speculative writes and clear all checkpoints.
- ready_out  in  1  consumer accepts data.
- valid_out  out  1  committed data is available.
- data_out  out  WIDTH  entry at the read pointer.
- commit_count  out  PW  committed entries not yet read.
- spec_count  out  PW  total entries held, committed plus speculative.
- ckpt_count  out  CW+1  outstanding checkpoints.

Behaviour:
- State:
  - rd_ptr, wr_ptr (commit point), spec_wr_ptr: PW bits each, wrapping naturally.
  - ckpt stack: NUM_CKPT x PW.
  - ckpt_cnt.
  - Storage array of DEPTH x WIDTH.
- Derived signals:
  - spec_count = spec_wr_ptr - rd_ptr.
  - commit_count = wr_ptr - rd_ptr.
  - ready_in = (spec_count != DEPTH); this is state-based, so a same-cycle read does not free space.
  - valid_out = (commit_count != 0).
  - data_out = mem[rd_ptr[AW-1:0]], read combinationally, so there is zero-latency show-ahead.
  - write = valid_in & ready_in.
  - read = ready_out & valid_out.
- Reset:
  - All pointers and ckpt_cnt are 0.
  - ready_in=1, valid_out=0, mark_ready=1, mark_id=0, all counts 0.
  - Memory contents are not reset.
- Write: mem[spec_wr_ptr] <= data_in, then spec_wr_ptr+1, unless discarded by the control-priority rules below.
- Read: rd_ptr+1. Reads are never affected by commit, revert or rollback.
- Control priority per cycle, evaluated on the current state:
  1. commit:
     - wr_ptr <= spec_wr_ptr + write.
     - spec_wr_ptr <= spec_wr_ptr + write.
     - ckpt_cnt <= 0.
     - A same-cycle write is included in the commit.
     - rollback, revert and mark are ignored.
  2. revert:
     - spec_wr_ptr <= wr_ptr; ckpt_cnt <= 0.
     - A same-cycle write is discarded: memory may be written, but the pointer does not keep it.
     - rollback and mark are ignored.
  3. rollback with rollback_id < ckpt_cnt:
     - spec_wr_ptr <= ckpt[rollback_id]; ckpt_cnt <= rollback_id.
     - Checkpoint rollback_id and all younger checkpoints are freed.
     - A same-cycle write is discarded; mark is ignored.
     - rollback_id >= ckpt_cnt is a no-op that ignores the rollback request; write and mark proceed normally. A simulation assertion flags it.
  4. mark with mark_ready:
     - ckpt[ckpt_cnt] <= spec_wr_ptr, taken before any same-cycle write.
     - ckpt_cnt+1.
     - A same-cycle write lands after the checkpoint, so rolling back to this checkpoint removes it.
- mark_ready = (ckpt_cnt != NUM_CKPT). A mark while the stack is full is dropped, and a simulation assertion flags it.
- Newly committed data raises valid_out on the cycle after commit, with no same-cycle bypass.
- Wrap-around: ckpt entries are full PW-bit pointers, valid across multiple wraps. The invariant rd_ptr <= wr_ptr <= every ckpt <= spec_wr_ptr always holds under modulo ordering.
- Full with a pending read: the write is refused that cycle (ready_in=0) and accepted the next cycle.
- Simultaneous read and commit or revert are independent; counts update by the sum of both effects.

Decomposition:
- Package spec_fifo_pkg holds:
  - localparam functions for AW, PW and CW.
  - A typedef ptr_t (logic [PW-1:0]), parameterised via a macro or function.
  - The control priority encoding as an enum ctl_e with values CTL_NONE, CTL_MARK, CTL_ROLLBACK, CTL_REVERT, CTL_COMMIT.
- One sub-module, ckpt_stack: the NUM_CKPT x PW LIFO with push, truncate-to-id and clear operations. It outputs the count, full flag and entry read-by-id.
- Memory stays inline in the top level.

Test Plan:
- Basic commit (DEPTH=16). Write 5 entries (0x10..0x14), then commit.
  - Before commit: valid_out stays 0.
  - After commit: commit_count=5, and reads return 0x10..0x14 in order.
- Full capacity. Write 16 entries with no reads.
  - Writes 1-16: ready_in stays 1 and all are accepted.
  - After the 16th: ready_in=0 and spec_count=16.
  - Then commit and read 16 entries: all values are correct, and wrap to ptr 0x10 is exercised.
- Nested rollback.
  - Sequence: write A; mark (id 0); write B; mark (id 1); write C; rollback id 1.
    - Result: spec_count=2, ckpt_count=1.
  - Then rollback id 0, then commit.
    - Result: only A is readable.
- Simultaneous events:
  - Commit with write D on the same cycle: D is committed.
  - Revert with write E on the same cycle: E is dropped, spec_count equals commit_count.
  - Commit and revert together: commit wins.
  - Mark with write F on the same cycle, then rollback to that id: F is removed.
- Checkpoint overflow and illegal id (NUM_CKPT=4).
  - 4 marks: mark_ready=0.
  - 5th mark: ignored, ckpt_count stays 4.
  - Commit, then rollback id 2 with ckpt_count=0: no state change, assertion fires.
- Reset mid-operation. Committed and speculative data plus 2 checkpoints are present; assert reset for 1 cycle.
  - Result: all counts are 0, valid_out=0, ready_in=1, mark_id=0.
  - The next write-commit-read sequence behaves normally.
